// File: rtl/lfsr_rr_arbiter.sv
// Round-robin access to one XNOR LFSR: one word per grant, registered 1-cycle latency, seed load plus warm-up.
// Requests are level-held until granted, with no other backpressure. LFSR_FREERUN_EN: generator also steps on idle RUN cycles.
module lfsr_rr_arbiter #(
  parameter int                NREQ     = 4,
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'('h0001_040C),
  parameter int                WARMUP   = 8,
  localparam int               IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_data_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [IDW-1:0]   rd_id_o,
  output logic             busy_o,
  output logic             seed_err_o
);

  typedef enum logic {WARM, RUN} fsm_e;

  fsm_e             fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [IDW-1:0]   ptr_q;
  logic [7:0]       wcnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [IDW-1:0]   rd_id_q;
  logic             busy_q;
  logic             seed_err_q;

  logic [WIDTH-1:0] state_d;
  logic             pick_vld_d;
  logic [IDW-1:0]   pick_idx_d;
  logic [IDW-1:0]   ptr_d;
  logic [IDW:0]     j;

  assign state_d = {state_q[WIDTH-2:0], ~^(state_q & TAP_MASK)};

  // Walk offsets from the highest down so the nearest requester at or after ptr wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    j          = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr_q} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (req_i[j[IDW-1:0]]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = j[IDW-1:0];
      end
    end
  end

  assign ptr_d = (pick_idx_d == IDW'(NREQ - 1)) ? '0 : pick_idx_d + IDW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= WARM;
      state_q    <= '0;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      busy_q     <= 1'b1;
      seed_err_q <= 1'b0;
    end else if (seed_load_i) begin
      // All-ones would lock the XNOR generator, so it is replaced by zero.
      state_q    <= (&seed_data_i) ? '0 : seed_data_i;
      seed_err_q <= &seed_data_i;
      wcnt_q     <= '0;
      fsm_q      <= WARM;
      busy_q     <= 1'b1;
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      seed_err_q <= 1'b0;
      case (fsm_q)
        WARM: begin
          state_q    <= state_d;
          gnt_q      <= '0;
          rd_valid_q <= 1'b0;
          if (wcnt_q == 8'(WARMUP - 1)) begin
            fsm_q  <= RUN;
            busy_q <= 1'b0;
            wcnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        RUN: begin
          if (pick_vld_d) begin
            gnt_q      <= NREQ'(1) << pick_idx_d;
            rd_valid_q <= 1'b1;
            rd_id_q    <= pick_idx_d;
            rd_data_q  <= state_q;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
          end else begin
            gnt_q      <= '0;
            rd_valid_q <= 1'b0;
`ifdef LFSR_FREERUN_EN
            state_q    <= state_d;
`else
            state_q    <= state_q;
`endif
          end
        end
        default: fsm_q <= WARM;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_id_o    = rd_id_q;
  assign busy_o     = busy_q;
  assign seed_err_o = seed_err_q;

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Scoreboard bench: reference model predicts each grant into a queue; a monitor pops and compares.
module tb_lfsr_rr_arbiter;
  localparam int          NREQ   = 4;
  localparam int          WARMUP = 8;
  localparam logic [31:0] TAPS   = 32'h0001_040C;
  localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic              seed_load;
  logic [31:0]       seed_data;
  logic [NREQ-1:0]   gnt;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [1:0]        rd_id;
  logic              busy;
  logic              seed_err;

  always #5 clk = ~clk;

  lfsr_rr_arbiter #(.NREQ(NREQ), .WIDTH(32), .TAP_MASK(TAPS), .WARMUP(WARMUP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .seed_load_i(seed_load), .seed_data_i(seed_data),
    .gnt_o(gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_id_o(rd_id),
    .busy_o(busy), .seed_err_o(seed_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    int              id;
    logic [31:0]     data;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  bit   exp_busy_a[8192];
  bit   exp_serr_a[8192];
  bit   mon_en = 1'b0;

  // Model state: the delivered word is the seed advanced by m_n generator steps.
  logic [31:0]     m_seed;
  int              m_n;
  int              m_warm_left;
  int              m_ptr;
  logic [NREQ-1:0] pend;

  logic [NREQ-1:0] s_gnt;
  logic            s_vld, s_serr;
  logic [31:0]     s_data;
  logic [1:0]      s_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] s, input int n);
    logic [31:0] w = s;
    for (int i = 0; i < n; i++) w = {w[30:0], ~^(w & TAPS)};
    return w;
  endfunction

  task automatic model_reset();
    m_seed = '0; m_n = 0; m_warm_left = WARMUP; m_ptr = 0; pend = '0;
    q.delete();
  endtask

  task automatic model_step();
    logic [NREQ-1:0] g = '0;
    bit serr = 1'b0;
    bit bsy;
    if (seed_load) begin
      serr = (seed_data == ONES);
      m_seed = serr ? 32'h0 : seed_data;
      m_n = 0; m_warm_left = WARMUP; bsy = 1'b1;
    end else if (m_warm_left > 0) begin
      m_n++; m_warm_left--; bsy = (m_warm_left > 0);
    end else begin
      bsy = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (g == '0 && req[idx]) begin
          exp_t e;
          g = NREQ'(1) << idx;
          e.cyc = cyc + 1; e.gnt = g; e.id = idx; e.data = word_at(m_seed, m_n);
          q.push_back(e);
          m_n++;
          m_ptr = (idx + 1) % NREQ;
        end
      end
`ifdef LFSR_FREERUN_EN
      if (g == '0) m_n++;
`endif
    end
    exp_busy_a[(cyc + 1) % 8192] = bsy;
    exp_serr_a[(cyc + 1) % 8192] = serr;
    pend = req & ~g;
  endtask

  task automatic cycle(input logic [NREQ-1:0] add, input bit ld = 1'b0, input logic [31:0] sd = 32'h0);
    @(negedge clk);
    s_gnt = gnt; s_vld = rd_valid; s_data = rd_data; s_id = rd_id; s_serr = seed_err;
    req = pend | add; seed_load = ld; seed_data = sd;
    model_step();
  endtask

  task automatic hit_reset(input string nm);
    mon_en = 1'b0;
    rst_n = 1'b0;
    req = '0; seed_load = 1'b0; seed_data = '0;
    #1;
    chk({nm, " gnt"}, 64'(gnt), 64'h0);
    chk({nm, " rd_valid"}, 64'(rd_valid), 64'h0);
    chk({nm, " rd_data"}, 64'(rd_data), 64'h0);
    chk({nm, " rd_id"}, 64'(rd_id), 64'h0);
    chk({nm, " seed_err"}, 64'(seed_err), 64'h0);
    chk({nm, " busy"}, 64'(busy), 64'h1);
    model_reset();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    exp_busy_a[cyc % 8192] = 1'b1;
    exp_serr_a[cyc % 8192] = 1'b0;
    model_step();
    mon_en = 1'b1;
  endtask

  task automatic reset_pulse(input string nm);
    @(negedge clk);
    #2;
    hit_reset(nm);
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(exp_busy_a[cyc % 8192]));
      chk("seed_err", 64'(seed_err), 64'(exp_serr_a[cyc % 8192]));
      chk("gnt onehot0", 64'($onehot0(gnt)), 64'h1);
      if (rd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected grant", 64'(gnt), 64'h0);
        end else begin
          mon_e = q.pop_front();
          chk("grant cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("gnt", 64'(gnt), 64'(mon_e.gnt));
          chk("rd_id", 64'(rd_id), 64'(mon_e.id));
          chk("rd_data", 64'(rd_data), 64'(mon_e.data));
        end
      end else begin
        chk("gnt idle", 64'(gnt), 64'h0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          mon_e = q.pop_front();
          chk("missed grant", 64'(rd_valid), 64'h1);
        end
      end
    end
  end

  initial begin
    int n;
    logic [NREQ-1:0] exp_seq [5];
    rst_n = 1'b1; req = '0; seed_load = 1'b0; seed_data = '0;
    model_reset();
    #2;
    hit_reset("reset");
    repeat (3) @(negedge clk);
    release_rst();

    // First two words from the zero state, requester 0 held from release.
    n = 0;
    for (int i = 1; i <= 20 && !s_vld; i++) begin cycle(4'b0001); n = i; end
    chk("first grant call", 64'(n), 64'd9);
    chk("first word", 64'(s_data), 64'h0000_00EC);
    chk("first gnt", 64'(s_gnt), 64'h1);
    cycle(4'b0000);
    chk("second word", 64'(s_data), 64'h0000_01D9);
    chk("second valid", 64'(s_vld), 64'h1);
    repeat (4) cycle(4'b0000);

    reset_pulse("reset2");
    repeat (7) cycle(4'b0000);
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111);
      if (i > 0) begin
        chk("rr all gnt", 64'(s_gnt), 64'(exp_seq[i-1]));
        chk("rr all id", 64'(s_id), 64'((i - 1) % NREQ));
      end
    end
    repeat (5) cycle(4'b0000);

    reset_pulse("reset3");
    repeat (7) cycle(4'b0000);
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1010);
      if (i > 0) chk("rr 1010 gnt", 64'(s_gnt), (i % 2 == 1) ? 64'h2 : 64'h8);
    end
    repeat (5) cycle(4'b0000);

    cycle(4'b0100, 1'b1, ONES);
    cycle(4'b0000);
    chk("lockup seed_err", 64'(s_serr), 64'h1);
    n = 1;
    for (int i = 2; i <= 25 && !s_vld; i++) begin cycle(4'b0000); n = i; end
    chk("lockup grant call", 64'(n), 64'd10);
    chk("lockup gnt", 64'(s_gnt), 64'h4);
    chk("lockup word", 64'(s_data), 64'h0000_00EC);
    repeat (3) cycle(4'b0000);

    cycle(4'b0001, 1'b1, 32'h0000_0001);
    for (int i = 0; i < 25 && !s_vld; i++) cycle(4'b0000);
    chk("seed1 word", 64'(s_data), 64'h0000_01D9);
    chk("seed1 id", 64'(s_id), 64'h0);
    #2;
    chk("pre-reset valid", 64'(rd_valid), 64'h1);
    hit_reset("mid-grant reset");
    repeat (2) @(negedge clk);
    release_rst();

    for (int i = 0; i < 1500; i++) begin
      logic [NREQ-1:0] a;
      bit ld;
      logic [31:0] sd;
      a  = NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15));
      ld = ($urandom_range(0, 39) == 0);
      sd = ($urandom_range(0, 3) == 0) ? ONES : 32'($urandom);
      cycle(a, ld, sd);
      if ($urandom_range(0, 499) == 0) reset_pulse("random reset");
    end
    repeat (15) cycle(4'b0000);
    chk("queue drained", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
